mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous memory between the instruction-fetch requester (I) and
//   the MEM-stage load/store requester (D). One transaction in flight; fixed priority D > I,

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester (I) and the load/store requester (D). One transaction in flight,
// fixed priority D over I, with a starvation override that forces an I grant
// after STARVE_LIMIT consecutive D grants while I was waiting.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // D (load/store) requester
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_rdata,
  // I (fetch) requester
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Counter widths: the starve counter must hold STARVE_LIMIT itself, the
  // latency counter must hold MEM_LATENCY-1.
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int LAT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  starve_cnt_q;
  logic [CNT_W-1:0]  starve_cnt_d;
  logic [LAT_W-1:0]  wait_cnt_q;
  logic              owner_i_q;     // 1 = current transaction belongs to I
  logic              we_q;          // current transaction is a store
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              d_resp_valid_q;
  logic [DATA_W-1:0] d_resp_rdata_q;
  logic              i_resp_valid_q;
  logic [DATA_W-1:0] i_resp_rdata_q;

  logic              idle_ok;
  logic              force_i;
  logic              d_grant;
  logic              i_grant;

  // Grant selection in IDLE and next value of the starvation counter.
  always_comb begin
    idle_ok      = (state_q == ST_IDLE) && !reset;
    force_i      = i_req_valid && (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);
    i_grant      = idle_ok && i_req_valid && (force_i || !d_req_valid);
    d_grant      = idle_ok && d_req_valid && !force_i;
    starve_cnt_d = starve_cnt_q;
    if (i_grant) begin
      starve_cnt_d = '0;
    end else if (d_grant && i_req_valid) begin
      if (starve_cnt_q != STARVE_MAX) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else if ((state_q == ST_IDLE) && !i_req_valid) begin
      starve_cnt_d = '0;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Transaction FSM with registered memory strobes and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      starve_cnt_q   <= '0;
      wait_cnt_q     <= '0;
      owner_i_q      <= 1'b0;
      we_q           <= 1'b0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      d_resp_valid_q <= 1'b0;
      d_resp_rdata_q <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_rdata_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (d_grant) begin
            owner_i_q   <= 1'b0;
            we_q        <= d_req_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_req_we;
            mem_addr_q  <= d_req_addr;
            mem_wdata_q <= d_req_wdata;
            state_q     <= ST_ISSUE;
          end else if (i_grant) begin
            owner_i_q  <= 1'b1;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_req_addr;
            state_q    <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The strobe lives for exactly this one cycle.
          mem_en_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          wait_cnt_q <= LAT_LOAD;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            if (owner_i_q) begin
              i_resp_valid_q <= 1'b1;
              i_resp_rdata_q <= mem_rdata;
            end else begin
              d_resp_valid_q <= 1'b1;
              d_resp_rdata_q <= we_q ? '0 : mem_rdata;
            end
            state_q <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - LAT_W'(1);
          end
        end
        ST_RESP: begin
          d_resp_valid_q <= 1'b0;
          i_resp_valid_q <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: begin
          mem_en_q       <= 1'b0;
          mem_we_q       <= 1'b0;
          d_resp_valid_q <= 1'b0;
          i_resp_valid_q <= 1'b0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_req_ready  = d_grant;
  assign i_req_ready  = i_grant;
  assign d_resp_valid = d_resp_valid_q;
  assign d_resp_rdata = d_resp_rdata_q;
  assign i_resp_valid = i_resp_valid_q;
  assign i_resp_rdata = i_resp_rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 for
// load/store/contention/reset cases, one with MEM_LATENCY=3 for fetch timing.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  // instance 1 (MEM_LATENCY=1)
  logic        d_valid, d_ready, d_we, d_resp_v;
  logic [31:0] d_addr, d_wdata, d_resp_d;
  logic        i_valid, i_ready, i_resp_v;
  logic [31:0] i_addr, i_resp_d;
  logic        m_en, m_we, busy1;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // instance 2 (MEM_LATENCY=3), I port only
  logic        d2_valid, d2_ready, d2_we, d2_resp_v;
  logic [31:0] d2_addr, d2_wdata, d2_resp_d;
  logic        i2_valid, i2_ready, i2_resp_v;
  logic [31:0] i2_addr, i2_resp_d;
  logic        m2_en, m2_we, busy2;
  logic [31:0] m2_addr, m2_wdata, m2_rdata;
  logic        s1, s2;
  logic [31:0] a1, a2;

  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .d_req_valid(d_valid), .d_req_ready(d_ready), .d_req_addr(d_addr),
    .d_req_we(d_we), .d_req_wdata(d_wdata),
    .d_resp_valid(d_resp_v), .d_resp_rdata(d_resp_d),
    .i_req_valid(i_valid), .i_req_ready(i_ready), .i_req_addr(i_addr),
    .i_resp_valid(i_resp_v), .i_resp_rdata(i_resp_d),
    .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata), .busy(busy1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .d_req_valid(d2_valid), .d_req_ready(d2_ready), .d_req_addr(d2_addr),
    .d_req_we(d2_we), .d_req_wdata(d2_wdata),
    .d_resp_valid(d2_resp_v), .d_resp_rdata(d2_resp_d),
    .i_req_valid(i2_valid), .i_req_ready(i2_ready), .i_req_addr(i2_addr),
    .i_resp_valid(i2_resp_v), .i_resp_rdata(i2_resp_d),
    .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
    .mem_rdata(m2_rdata), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model, latency 1: read data valid only in the cycle after mem_en.
  always @(posedge clk) begin
    m_rdata <= (m_en && !m_we) ? mem[m_addr[9:0]] : 32'hBAD0_BAD0;
  end

  // Memory model, latency 3: read data valid only three cycles after mem_en.
  always @(posedge clk) begin
    s1       <= m2_en && !m2_we;
    a1       <= m2_addr;
    s2       <= s1;
    a2       <= a1;
    m2_rdata <= s2 ? mem[a2[9:0]] : 32'hBAD3_BAD3;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic       both;
    logic [5:0] seq;
    int         grants;

    for (int k = 0; k < 1024; k++) mem[k] = 32'hA500_0000 | k;
    mem[10'h040] = 32'hDEAD_BEEF;
    mem[10'h100] = 32'h1234_5678;

    reset = 1'b1;
    d_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_wdata = 32'h0;
    i_valid = 1'b0; i_addr = 32'h0;
    d2_valid = 1'b0; d2_addr = 32'h0; d2_we = 1'b0; d2_wdata = 32'h0;
    i2_valid = 1'b0; i2_addr = 32'h0;

    // ---- 1: reset state
    tick; tick;
    check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_i_ready", i_ready, 0);
    check_eq("rst_d_resp_valid", d_resp_v, 0);
    check_eq("rst_d_resp_rdata", d_resp_d, 0);
    check_eq("rst_i_resp_valid", i_resp_v, 0);
    check_eq("rst_i_resp_rdata", i_resp_d, 0);
    check_eq("rst_mem_en", m_en, 0);
    check_eq("rst_mem_we", m_we, 0);
    check_eq("rst_mem_addr", m_addr, 0);
    check_eq("rst_mem_wdata", m_wdata, 0);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_busy_lat3", busy2, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick;
      if (m_en || m2_en || busy1) seen = 1'b1;
    end
    check_eq("idle_no_mem_en", seen, 0);

    // ---- 2: D load, latency 1
    d_valid = 1'b1; d_addr = 32'h40; d_we = 1'b0;
    #1;
    check_eq("ld_d_ready_T", d_ready, 1);
    check_eq("ld_i_ready_T", i_ready, 0);
    tick;                                   // T+1
    d_valid = 1'b0;
    check_eq("ld_mem_en_T1", m_en, 1);
    check_eq("ld_mem_we_T1", m_we, 0);
    check_eq("ld_mem_addr_T1", m_addr, 32'h40);
    check_eq("ld_busy_T1", busy1, 1);
    check_eq("ld_resp_T1", d_resp_v, 0);
    tick;                                   // T+2
    check_eq("ld_mem_en_T2", m_en, 0);
    check_eq("ld_mem_addr_hold_T2", m_addr, 32'h40);
    check_eq("ld_resp_T2", d_resp_v, 0);
    tick;                                   // T+3
    check_eq("ld_resp_T3", d_resp_v, 1);
    check_eq("ld_rdata_T3", d_resp_d, 32'hDEAD_BEEF);
    check_eq("ld_i_resp_T3", i_resp_v, 0);
    tick;                                   // T+4
    check_eq("ld_resp_T4", d_resp_v, 0);
    check_eq("ld_busy_T4", busy1, 0);

    // ---- 3: D store
    d_valid = 1'b1; d_addr = 32'h7A; d_we = 1'b1; d_wdata = 32'h15;
    #1;
    check_eq("st_d_ready_T", d_ready, 1);
    tick;                                   // T+1
    d_valid = 1'b0; d_we = 1'b0;
    check_eq("st_mem_en_T1", m_en, 1);
    check_eq("st_mem_we_T1", m_we, 1);
    check_eq("st_mem_addr_T1", m_addr, 32'h7A);
    check_eq("st_mem_wdata_T1", m_wdata, 32'h15);
    tick;                                   // T+2
    check_eq("st_mem_we_T2", m_we, 0);
    tick;                                   // T+3
    check_eq("st_resp_T3", d_resp_v, 1);
    check_eq("st_rdata_T3", d_resp_d, 0);
    tick;                                   // T+4

    // ---- 4: contention, STARVE_LIMIT=4 -> D,D,D,D,I,D
    d_valid = 1'b1; d_addr = 32'h40; d_we = 1'b0;
    i_valid = 1'b1; i_addr = 32'h100;
    grants = 0; seq = 6'b0; both = 1'b0;
    for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
      #1;
      if (d_ready && i_ready) both = 1'b1;
      if (d_ready || i_ready) begin
        seq[grants] = i_ready;
        grants++;
      end
      tick;
    end
    d_valid = 1'b0; i_valid = 1'b0;
    check_eq("cont_grant_count", grants, 6);
    check_eq("cont_grant_order", seq, 6'b010000);
    check_eq("cont_never_both_ready", both, 0);
    repeat (6) tick;

    // ---- 5: I fetch with MEM_LATENCY=3
    i2_valid = 1'b1; i2_addr = 32'h100;
    #1;
    check_eq("l3_i_ready_T", i2_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) check_eq("l3_mem_en_T1", m2_en, 1);
      if (k <= 5) check_eq($sformatf("l3_ready_T%0d", k), i2_ready, 0);
      else        check_eq("l3_ready_T6", i2_ready, 1);
      check_eq($sformatf("l3_resp_T%0d", k), i2_resp_v, (k == 5) ? 1 : 0);
      if (k == 5) check_eq("l3_rdata_T5", i2_resp_d, 32'h1234_5678);
    end
    tick;
    i2_valid = 1'b0;
    repeat (6) tick;

    // ---- 6: reset in WAIT abandons the transaction
    d_valid = 1'b1; d_addr = 32'h40; d_we = 1'b0;
    #1;
    check_eq("rw_d_ready_T", d_ready, 1);
    tick;                                   // T+1 ISSUE
    d_valid = 1'b0;
    tick;                                   // T+2 WAIT
    check_eq("rw_busy_T2", busy1, 1);
    reset = 1'b1;
    tick;                                   // T+3
    check_eq("rw_resp_after_reset", d_resp_v, 0);
    check_eq("rw_busy_after_reset", busy1, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick;
      if (d_resp_v || m_en) seen = 1'b1;
    end
    check_eq("rw_no_late_activity", seen, 0);
    d_valid = 1'b1; d_addr = 32'h40; d_we = 1'b0;
    #1;
    check_eq("rw2_d_ready_T", d_ready, 1);
    tick;
    d_valid = 1'b0;
    tick;
    tick;
    check_eq("rw2_resp_T3", d_resp_v, 1);
    check_eq("rw2_rdata_T3", d_resp_d, 32'hDEAD_BEEF);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
